// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the three memory requesters, the port arbiter and the
// single-port synchronous memory. Requester slices are packed side by side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic [2:0]          req;
  logic [2:0]          req_we;
  logic [3*ADDR_W-1:0] req_adr;
  logic [3*LEN_W-1:0]  req_len;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          gnt;
  logic [2:0]          beat;
  logic [2:0]          last;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_adr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;

  modport slave (
    input  req, req_we, req_adr, req_len, req_wdata, mem_rdata,
    output gnt, beat, last, rvalid, rdata, mem_en, mem_we, mem_adr, mem_wdata, busy
  );

  modport master (
    output req, req_we, req_adr, req_len, req_wdata, mem_rdata,
    input  gnt, beat, last, rvalid, rdata, mem_en, mem_we, mem_adr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter for the shared image/filter memory: grants whole
// bursts, walks beat addresses and routes read returns back to the owner.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [1:0]        id;
  logic [1:0]        rr_ptr;
  logic              we;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W:0]    cnt;
  logic [2:0]        gnt_q;
  logic [2:0]        beat_q;
  logic [2:0]        last_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic              rd_valid;
  logic [1:0]        rd_id;

  logic [1:0]        win;
  logic [2:0]        win_oh;
  logic              win_we;
  logic [ADDR_W-1:0] win_adr;
  logic [LEN_W-1:0]  win_len;
  logic [DATA_W-1:0] own_wdata;
  logic [LEN_W:0]    cnt_next;

  // First requester at or after rr_ptr wins, wrapping 2 -> 0.
  always_comb begin
    case (rr_ptr)
      2'd1:    win = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd2:    win = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    win_oh    = 3'b001 << win;
    win_we    = 1'b0;
    win_adr   = '0;
    win_len   = '0;
    own_wdata = '0;
    cnt_next  = cnt + 1'b1;
    case (win)
      2'd0: begin
        win_we  = bus.req_we[0];
        win_adr = bus.req_adr[0 +: ADDR_W];
        win_len = bus.req_len[0 +: LEN_W];
      end
      2'd1: begin
        win_we  = bus.req_we[1];
        win_adr = bus.req_adr[ADDR_W +: ADDR_W];
        win_len = bus.req_len[LEN_W +: LEN_W];
      end
      default: begin
        win_we  = bus.req_we[2];
        win_adr = bus.req_adr[2*ADDR_W +: ADDR_W];
        win_len = bus.req_len[2*LEN_W +: LEN_W];
      end
    endcase
    case (id)
      2'd0:    own_wdata = bus.req_wdata[0 +: DATA_W];
      2'd1:    own_wdata = bus.req_wdata[DATA_W +: DATA_W];
      default: own_wdata = bus.req_wdata[2*DATA_W +: DATA_W];
    endcase
  end

  // Outputs are registered one cycle ahead: the IDLE->BURST edge already loads beat 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      id        <= '0;
      rr_ptr    <= '0;
      we        <= 1'b0;
      base      <= '0;
      len       <= '0;
      cnt       <= '0;
      gnt_q     <= '0;
      beat_q    <= '0;
      last_q    <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state     <= BURST;
            id        <= win;
            we        <= win_we;
            base      <= win_adr;
            len       <= win_len;
            cnt       <= '0;
            gnt_q     <= win_oh;
            beat_q    <= win_oh;
            last_q    <= (win_len == '0) ? win_oh : 3'b000;
            mem_en_q  <= 1'b1;
            mem_we_q  <= win_we;
            mem_adr_q <= win_adr;
          end
        end
        BURST: begin
          if (cnt == {1'b0, len}) begin
            state     <= IDLE;
            rr_ptr    <= (id == 2'd2) ? 2'd0 : id + 2'd1;
            gnt_q     <= '0;
            beat_q    <= '0;
            last_q    <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
          end else begin
            cnt       <= cnt_next;
            mem_adr_q <= base + ADDR_W'(cnt_next);
            last_q    <= (cnt_next == {1'b0, len}) ? gnt_q : 3'b000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path is independent of the FSM so the last read beat's valid
  // still lands while the next burst is being set up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      rd_valid <= mem_en_q & ~mem_we_q;
      rd_id    <= id;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.beat      = beat_q;
  assign bus.last      = last_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_en_q ? own_wdata : '0;
  assign bus.busy      = (state == BURST);
  assign bus.rvalid    = rd_valid ? (3'b001 << rd_id) : 3'b000;
  // mem_rdata is already the memory's output register; forward it while valid.
  assign bus.rdata     = rd_valid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected beats are queued with their
// cycle number when requests are launched and checked as the DUT issues them.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   seen0 = 0;
  int   pushed0 = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic        we;
    logic [15:0] adr;
    logic        last;
    logic [31:0] wdata;
  } beat_t;

  beat_t       sbq[$];
  logic [2:0]  exp_rv = 3'b000;
  logic [31:0] exp_rd = '0;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32), .LEN_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] memVal(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= memVal(bus.mem_adr);
  end

  // Requester 0 advances its write data after each of its beats.
  always @(posedge clk) begin
    #1;
    bus.req_wdata = {64'h0, 32'hD0D0_0000 + seen0};
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    beat_t       b;
    logic [2:0]  oh;
    logic [2:0]  nxt_rv;
    logic [31:0] nxt_rd;
    nxt_rv = 3'b000;
    nxt_rd = '0;
    if (!rst) begin
      sbq.delete();
      exp_rv = 3'b000;
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      b  = sbq.pop_front();
      oh = 3'b001 << b.id;
      checkOutput("gnt", bus.gnt, oh);
      checkOutput("beat", bus.beat, oh);
      checkOutput("last", bus.last, b.last ? oh : 3'b000);
      checkOutput("mem_en", bus.mem_en, 1);
      checkOutput("mem_we", bus.mem_we, b.we);
      checkOutput("mem_adr", bus.mem_adr, b.adr);
      checkOutput("busy", bus.busy, 1);
      if (b.we) checkOutput("mem_wdata", bus.mem_wdata, b.wdata);
      else begin
        nxt_rv = oh;
        nxt_rd = memVal(b.adr);
      end
    end else begin
      checkOutput("idle", {bus.gnt, bus.beat, bus.last, bus.mem_en, bus.busy}, 0);
    end
    checkOutput("rvalid", bus.rvalid, exp_rv);
    if (exp_rv != 3'b000) checkOutput("rdata", bus.rdata, exp_rd);
    exp_rv = nxt_rv;
    exp_rd = nxt_rd;
    if (bus.beat[0]) seen0++;
  end

  // Park at 2 time units after the posedge that starts the target cycle.
  task automatic goCycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input int i, input logic w, input logic [15:0] adr,
                               input logic [7:0] len, input int start);
    beat_t b;
    bus.req[i]           = 1'b1;
    bus.req_we[i]        = w;
    bus.req_adr[i*16 +: 16] = adr;
    bus.req_len[i*8 +: 8]   = len;
    for (int k = 0; k <= int'(len); k++) begin
      b.cyc   = start + k;
      b.id    = 2'(i);
      b.we    = w;
      b.adr   = adr + 16'(k);
      b.last  = (k == int'(len));
      b.wdata = 32'hD0D0_0000 + pushed0;
      if (i == 0) pushed0++;
      sbq.push_back(b);
    end
  endtask

  initial begin
    int c;
    rst         = 1'b0;
    bus.req     = '0;
    bus.req_we  = '0;
    bus.req_adr = '0;
    bus.req_len = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_out", {bus.gnt, bus.beat, bus.last, bus.rvalid, bus.mem_en, bus.mem_we, bus.busy}, 0);
    checkOutput("rst_adr", bus.mem_adr, 0);
    rst = 1'b1;
    goCycle(cyc + 2);

    $display("[TB] single read burst");
    c = cyc;
    applyStimulus(1, 1'b0, 16'h0100, 8'd3, c + 1);
    goCycle(c + 1);
    bus.req[1] = 1'b0;
    goCycle(c + 8);

    $display("[TB] write burst");
    c = cyc;
    applyStimulus(0, 1'b1, 16'h0010, 8'd2, c + 1);
    goCycle(c + 1);
    bus.req[0] = 1'b0;
    goCycle(c + 7);

    $display("[TB] address wrap");
    c = cyc;
    applyStimulus(2, 1'b0, 16'hFFFE, 8'd3, c + 1);
    goCycle(c + 1);
    bus.req[2] = 1'b0;
    goCycle(c + 8);

    $display("[TB] back-to-back reads");
    c = cyc;
    applyStimulus(1, 1'b0, 16'h0040, 8'd0, c + 1);
    applyStimulus(2, 1'b0, 16'h0080, 8'd2, c + 3);
    goCycle(c + 1);
    bus.req[1] = 1'b0;
    goCycle(c + 3);
    bus.req[2] = 1'b0;
    goCycle(c + 9);

    $display("[TB] reset mid-burst");
    c = cyc;
    applyStimulus(1, 1'b0, 16'h0200, 8'd7, c + 1);
    goCycle(c + 1);
    bus.req[1] = 1'b0;
    goCycle(c + 3);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_out", {bus.gnt, bus.beat, bus.last, bus.rvalid, bus.mem_en, bus.busy}, 0);
    checkOutput("rst_mid_adr", bus.mem_adr, 0);
    goCycle(c + 5);
    rst = 1'b1;
    goCycle(c + 9);

    $display("[TB] three-way round robin");
    c = cyc;
    applyStimulus(0, 1'b0, 16'h0300, 8'd0, c + 1);
    applyStimulus(1, 1'b0, 16'h0400, 8'd0, c + 3);
    applyStimulus(2, 1'b0, 16'h0500, 8'd0, c + 5);
    applyStimulus(0, 1'b0, 16'h0300, 8'd0, c + 7);
    goCycle(c + 7);
    bus.req = '0;
    goCycle(c + 11);

    checkOutput("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
